// File: rtl/urex2_sprite_fetch_if.sv
// urex2_sprite_fetch_if: pixel, sprite-control, ROM and palette signals of the sprite fetch stage
interface urex2_sprite_fetch_if #(
  parameter int ADDR_W = 12,
  parameter int FW     = 2
);
  logic [9:0]        draw_x;
  logic [9:0]        draw_y;
  logic              frame_start;
  logic [9:0]        sprite_x;
  logic [9:0]        sprite_y;
  logic              flip_h;
  logic              anim_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_data;
  logic [3:0]        pal_index;
  logic              hit;
  logic [FW-1:0]     anim_frame;
  modport master (
    output draw_x, draw_y, frame_start, sprite_x, sprite_y, flip_h, anim_en, rom_data,
    input  rom_addr, pal_index, hit, anim_frame
  );
  modport slave (
    input  draw_x, draw_y, frame_start, sprite_x, sprite_y, flip_h, anim_en, rom_data,
    output rom_addr, pal_index, hit, anim_frame
  );
endinterface

// File: rtl/urex2_sprite_fetch.sv
// urex2_sprite_fetch: per-pixel sprite box test, ROM address generation and 3-cycle colour index pipeline
module urex2_sprite_fetch #(
  parameter int         SPR_W           = 32,
  parameter int         SPR_H           = 32,
  parameter int         NUM_FRAMES      = 4,
  parameter int         FRAME_HOLD      = 8,
  parameter int         ADDR_W          = 12,
  parameter logic [3:0] TRANSPARENT_IDX = 4'd1
) (
  input logic clk,
  input logic rst_n,
  urex2_sprite_fetch_if.slave bus
);
  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);
  localparam int FW = NUM_FRAMES > 1 ? $clog2(NUM_FRAMES) : 1;
  localparam int HW = FRAME_HOLD > 1 ? $clog2(FRAME_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_MAX  = HW'(FRAME_HOLD - 1);
  localparam logic [FW-1:0] FRAME_MAX = FW'(NUM_FRAMES - 1);
  logic [9:0]        sx, sy;
  logic              flip;
  logic [HW-1:0]     hold;
  logic [FW-1:0]     frame;
  logic [ADDR_W-1:0] addr;
  logic              v1, v2;
  logic [3:0]        pal;
  logic              hit_r;
  logic [10:0]       x_end, y_end;
  logic              in_box;
  logic [CW-1:0]     col, col_f;
  logic [RW-1:0]     row;
  logic [ADDR_W-1:0] next_addr;
  // 11-bit box ends keep sprites straddling the right/bottom edge from wrapping to 0
  always_comb begin
    x_end     = {1'b0, sx} + 11'(SPR_W);
    y_end     = {1'b0, sy} + 11'(SPR_H);
    in_box    = bus.draw_x >= sx && {1'b0, bus.draw_x} < x_end &&
                bus.draw_y >= sy && {1'b0, bus.draw_y} < y_end;
    col       = CW'(bus.draw_x - sx);
    row       = RW'(bus.draw_y - sy);
    col_f     = flip ? ~col : col;
    next_addr = ADDR_W'({frame, row, col_f});
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sx    <= '0;
      sy    <= '0;
      flip  <= 1'b0;
      hold  <= '0;
      frame <= '0;
      addr  <= '0;
      v1    <= 1'b0;
      v2    <= 1'b0;
      pal   <= TRANSPARENT_IDX;
      hit_r <= 1'b0;
    end else begin
      if (bus.frame_start) begin
        sx   <= bus.sprite_x;
        sy   <= bus.sprite_y;
        flip <= bus.flip_h;
        if (bus.anim_en) begin
          if (hold < HOLD_MAX) hold <= hold + 1'b1;
          else begin
            hold  <= '0;
            frame <= frame == FRAME_MAX ? '0 : frame + 1'b1;
          end
        end
      end
      if (in_box) addr <= next_addr;
      v1    <= in_box;
      v2    <= v1;
      pal   <= v2 ? bus.rom_data : TRANSPARENT_IDX;
      hit_r <= v2 && bus.rom_data != TRANSPARENT_IDX;
    end
  end
  assign bus.rom_addr   = addr;
  assign bus.pal_index  = pal;
  assign bus.hit        = hit_r;
  assign bus.anim_frame = frame;
endmodule

// File: tb/tb_urex2_sprite_fetch.sv
// tb_urex2_sprite_fetch: directed checks of box test, addressing, flip, animation and reset
module tb_urex2_sprite_fetch;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  logic [3:0] rom [4096];
  always #5 clk = ~clk;
  urex2_sprite_fetch_if #(.ADDR_W(12), .FW(2)) bus ();
  urex2_sprite_fetch dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always_ff @(posedge clk) bus.rom_data <= rom[bus.rom_addr];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.draw_x = 10'd639;
    bus.draw_y = 10'd479;
  endtask
  task automatic fetch(input string tag, input int x, input int y, input int ea, input int ep, input int eh);
    bus.draw_x = 10'(x);
    bus.draw_y = 10'(y);
    tick();
    chk({tag, "_addr"}, 32'(bus.rom_addr), 32'(ea));
    idle();
    tick();
    tick();
    chk({tag, "_pal"}, 32'(bus.pal_index), 32'(ep));
    chk({tag, "_hit"}, 32'(bus.hit), 32'(eh));
  endtask
  task automatic pulse(input int x, input int y, input logic f);
    bus.sprite_x = 10'(x);
    bus.sprite_y = 10'(y);
    bus.flip_h = f;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    tick();
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 4'(i);
    rom[12'h043] = 4'd5;
    rom[12'h05C] = 4'd1;
    rst_n = 1'b0;
    bus.frame_start = 1'b0;
    bus.anim_en = 1'b0;
    bus.flip_h = 1'b0;
    bus.sprite_x = 10'd100;
    bus.sprite_y = 10'd50;
    bus.draw_x = 10'd100;
    bus.draw_y = 10'd50;
    tick();
    tick();
    chk("rst_pal", 32'(bus.pal_index), 32'd1);
    chk("rst_hit", 32'(bus.hit), 32'd0);
    chk("rst_addr", 32'(bus.rom_addr), 32'd0);
    chk("rst_frame", 32'(bus.anim_frame), 32'd0);
    rst_n = 1'b1;
    idle();
    tick();
    fetch("shadow0", 3, 2, 'h043, 5, 1);
    pulse(100, 50, 1'b0);
    fetch("basic", 103, 52, 'h043, 5, 1);
    pulse(100, 50, 1'b1);
    fetch("flip", 103, 52, 'h05C, 1, 0);
    pulse(620, 50, 1'b0);
    fetch("left_out", 619, 50, 'h05C, 1, 0);
    fetch("right_edge", 639, 50, 'h013, 3, 1);
    fetch("no_wrap", 5, 50, 'h013, 1, 0);
    pulse(100, 50, 1'b0);
    fetch("right_out", 132, 52, 'h013, 1, 0);
    fetch("last_col", 131, 52, 'h05F, 15, 1);
    pulse(100, 460, 1'b0);
    fetch("bottom", 100, 479, 'h260, 0, 1);
    fetch("no_vwrap", 100, 0, 'h260, 1, 0);
    fetch("far_x", 100, 460, 'h000, 0, 1);
    pulse(700, 460, 1'b0);
    fetch("off_screen", 0, 460, 'h000, 1, 0);
    pulse(100, 460, 1'b0);
    bus.sprite_x = 10'd300;
    fetch("mid_frame", 102, 460, 'h002, 2, 1);
    fetch("mid_frame_new", 302, 460, 'h002, 1, 0);
    bus.frame_start = 1'b1;
    bus.draw_x = 10'd103;
    bus.draw_y = 10'd460;
    tick();
    bus.frame_start = 1'b0;
    chk("fs_old_shadow", 32'(bus.rom_addr), 32'h003);
    idle();
    tick();
    fetch("fs_new_shadow", 305, 460, 'h005, 5, 1);
    bus.anim_en = 1'b1;
    for (int p = 1; p <= 32; p++) begin
      pulse(300, 460, 1'b0);
      if (p == 7) chk("anim_p7", 32'(bus.anim_frame), 32'd0);
      if (p == 8) chk("anim_p8", 32'(bus.anim_frame), 32'd1);
      if (p == 16) begin
        chk("anim_p16", 32'(bus.anim_frame), 32'd2);
        fetch("frame2", 300, 460, 'h800, 0, 1);
      end
      if (p == 24) chk("anim_p24", 32'(bus.anim_frame), 32'd3);
      if (p == 32) chk("anim_p32", 32'(bus.anim_frame), 32'd0);
    end
    for (int p = 0; p < 4; p++) pulse(300, 460, 1'b0);
    bus.anim_en = 1'b0;
    for (int p = 0; p < 10; p++) pulse(300, 460, 1'b0);
    chk("anim_freeze", 32'(bus.anim_frame), 32'd0);
    bus.anim_en = 1'b1;
    for (int p = 0; p < 4; p++) pulse(300, 460, 1'b0);
    chk("anim_resume", 32'(bus.anim_frame), 32'd1);
    bus.anim_en = 1'b0;
    bus.draw_x = 10'd302;
    bus.draw_y = 10'd460;
    tick();
    chk("inflight_addr", 32'(bus.rom_addr), 32'h402);
    idle();
    rst_n = 1'b0;
    tick();
    chk("rst_mid_hit", 32'(bus.hit), 32'd0);
    chk("rst_mid_pal", 32'(bus.pal_index), 32'd1);
    chk("rst_mid_frame", 32'(bus.anim_frame), 32'd0);
    tick();
    chk("rst_mid_hit2", 32'(bus.hit), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_hit", 32'(bus.hit), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/urex2_sprite_fetch.md
Name: urex2_sprite_fetch

Overview:
- Per-pixel sprite fetch stage for the urex2 enemy sprite. It sits directly upstream of the urex2 colour palette lookup.
- For each VGA pixel it decides whether the pixel lies inside the sprite box and computes the sprite ROM address. Frame selection and horizontal mirroring are applied here.
- It then issues the read, takes the 4-bit colour index back from the synchronous sprite ROM, and presents that index plus a hit flag to the palette and colour mapper.
- Position, facing and animation frame are latched once per video frame, so the sprite does not tear mid-frame.

Parameters:
- SPR_W, 32, sprite width in pixels (power of two).
- SPR_H, 32, sprite height in pixels (power of two).
- NUM_FRAMES, 4, number of animation frames stored back-to-back in the ROM.
- FRAME_HOLD, 8, video frames each animation frame is shown (≥1).
- ADDR_W, 12, ROM address width. Must satisfy 2^ADDR_W ≥ NUM_FRAMES*SPR_W*SPR_H.
- TRANSPARENT_IDX, 1, colour index treated as transparent.

Ports:
- Clk  in  1  pixel clock. Every cycle is one pixel.
- Reset_n  in  1  synchronous, active-low reset.
- DrawX  in  10  current pixel column, 0..639.
- DrawY  in  10  current pixel row, 0..479.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- SpriteX  in  10  sprite top-left column (unsigned).
- SpriteY  in  10  sprite top-left row (unsigned).
- flip_h  in  1  1 = mirror sprite horizontally.
- anim_en  in  1  1 = animation advances.
- rom_addr  out  ADDR_W  sprite ROM read address (registered).
- rom_data  in  4  ROM colour index. Valid the cycle after rom_addr.
- pal_index  out  4  colour index to the palette lookup.
- hit  out  1  1 = sprite pixel is opaque and should override background.
- anim_frame  out  log2(NUM_FRAMES)  current animation frame (debug/status).

Behaviour:
- Reset (Reset_n=0 at a Clk edge):
  - Shadow SpriteX/SpriteY/flip_h cleared to 0.
  - Hold counter and anim_frame cleared to 0.
  - rom_addr cleared to 0.
  - Pipeline valid bits cleared.
  - pal_index set to TRANSPARENT_IDX; hit set to 0.
- Reset asserted mid-frame discards in-flight pixels. hit is 0 from the first cycle after the reset edge.
- Shadow latch: on a cycle with frame_start=1, shadow registers load SpriteX, SpriteY and flip_h. The new values affect pixels sampled from the next cycle onward. Outside frame_start, input changes are ignored.
- Animation counter (on frame_start):
  - Updates only when anim_en=1.
  - If hold < FRAME_HOLD-1, hold increments.
  - Otherwise hold wraps to 0 and anim_frame increments, wrapping NUM_FRAMES-1 → 0.
  - anim_en=0 freezes both counters.
  - FRAME_HOLD=1 advances anim_frame on every frame_start.
- Stage 0, cycle N, inputs sampled:
  - Compute in-box flag as DrawX ≥ sx && DrawX < sx+SPR_W && DrawY ≥ sy && DrawY < sy+SPR_H. Use 11-bit sums so boxes crossing the right or bottom screen edge do not wrap.
  - col = DrawX−sx; row = DrawY−sy, both truncated to log2 width/height.
  - If flip, col = SPR_W−1−col.
  - At the end of N, register rom_addr = anim_frame*SPR_W*SPR_H + row*SPR_W + col, and register valid1 = in-box.
  - When out of box, rom_addr holds its previous value.
- Stage 1, cycle N+1: ROM performs the read; valid2 ← valid1.
- Stage 2, end of cycle N+2:
  - pal_index ← rom_data if valid2, else TRANSPARENT_IDX.
  - hit ← valid2 && rom_data ≠ TRANSPARENT_IDX.
- Latency: outputs for the pixel sampled in cycle N are visible in cycle N+3. Throughput is one pixel per clock, with no stalls. The downstream colour mapper delays DrawX/DrawY by 3 to match.
- Boundaries:
  - A sprite partly off the right or bottom edge draws only its on-screen part, with no wrap to column 0.
  - SpriteX > 639 means nothing is drawn.
  - frame_start coincident with a visible pixel uses the old shadow values for that pixel.

Test Plan:
1. Reset: hold Reset_n=0 for 2 cycles with DrawX=SpriteX → pal_index=1 and hit=0. After release, shadow = 0 and anim_frame = 0.
2. Basic fetch:
   - Stimulus: frame_start with SpriteX=100, SpriteY=50, flip_h=0; then DrawX=103, DrawY=52.
   - rom_addr=0x043 one cycle later.
   - ROM returns 5 → pal_index=5, hit=1 three cycles after sampling.
3. Flip and transparency:
   - Same position with flip_h=1, DrawX=103, DrawY=52 → rom_addr=0x05C.
   - ROM returns 1 → pal_index=1, hit=0.
4. Box edges:
   - SpriteX=620: DrawX=619 → hit=0; DrawX=639 → in-box with col=19.
   - DrawX=132 with SpriteX=100 → hit=0.
   - Verify no spurious hit near column 0 when SpriteX=620.
5. Animation:
   - With anim_en=1 and FRAME_HOLD=8, issue 32 frame_start pulses. anim_frame steps 0→1 on pulse 8, reaches 3 on pulse 24, and wraps to 0 on pulse 32.
   - At frame 2, DrawX=SpriteX and DrawY=SpriteY → rom_addr=0x800.
   - With anim_en=0, anim_frame holds.
6. Mid-update and reset:
   - Change SpriteX mid-frame → no effect until the next frame_start.
   - Assert Reset_n=0 while a hit pixel is in flight → hit=0 from the cycle after the reset edge.
